dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port data memory between the Fetch requester (read-only) and the Memory-stage requester (read/write) in the Y86-64 processor. Arbitrates round-robin, sequences one backend transaction at a time through a req/ack handshake, and returns data or an error to the winning requester. Sits between the Fetch and Memory stages and the memory array or model.

## Interface
Parameters:
- AW, 64, address width (byte address).
- DW, 64, data width.
- MEM_BYTES, 1024, size of the backing memory in bytes.
- TIMEOUT, 15, maximum BUSY cycles allowed without mem_ack.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- f_req  in  1  Fetch read request.
- f_addr  in  AW  Fetch address.
- f_ack  out  1  one-cycle completion pulse to Fetch.
- f_rdata  out  DW  read data, valid while f_ack=1, 0 otherwise.
- f_err  out  1  error flag, valid while f_ack=1.
- m_req  in  1  Memory-stage request.
- m_we  in  1  1 = write, 0 = read.
- m_addr  in  AW  Memory-stage address (valE).
- m_wdata  in  DW  write data (valA).
- m_ack, m_rdata, m_err  out  1/DW/1  as for the f_ port.
- mem_req  out  1  backend request, held until mem_ack or timeout.
- mem_we, mem_addr, mem_wdata  out  1/AW/DW  latched transaction fields.
- mem_ack  in  1  backend completion.
- mem_rdata  in  DW  backend read data, valid with mem_ack.
- busy  out  1  high in BUSY and RESP.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: samples f_req and m_req.
  - If neither is high, stay in IDLE.
  - If exactly one is high, grant it.
  - If both are high, grant the port not granted last.
  - On grant, latch the address, write-enable (forced to 0 for Fetch) and write data, then go to BUSY.
- BUSY: drive mem_req=1 with the latched fields.
  - Timeout counter starts at 0 on entry and increments each BUSY cycle.
  - On mem_ack: capture mem_rdata (0 for writes), set err=0, go to RESP.
  - If mem_ack has not arrived after TIMEOUT BUSY cycles: drop mem_req, set rdata=0 and err=1, go to RESP.
  - If mem_ack and timeout occur in the same cycle, mem_ack wins (err=0).
- RESP: pulse ack for one cycle on the granted port only, with rdata/err; the other port's outputs stay 0. Return to IDLE.
- Requester rules:
  - Hold req and all fields stable until ack.
  - The arbiter ignores field changes after the grant.
  - A req still high in the cycle after ack is a new request.
- Round-robin pointer: records the last granted port; resets to "Fetch last", so M wins the first tie.
- Reset, including mid-transaction: state to IDLE; mem_req, mem_we, acks, errs, busy to 0; all data/address outputs to 0; counter to 0; pointer to Fetch-last. An in-flight backend transaction is abandoned without a response.

## Timing
- Registered outputs only; no combinational path from req to mem_req or to ack.
- Minimum latency:
  - req high in cycle 0 is granted at edge 1.
  - mem_req is high in cycle 1.
  - mem_ack in cycle 1 is sampled at edge 2.
  - ack is high in cycle 2.
  - IDLE in cycle 3.
- Best-case throughput: one transaction per 3 cycles.
- Backend latency of L cycles gives ack at cycle L+1 after the grant.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then err ack appears the following cycle.
- Starvation bound: with both ports requesting continuously, grants alternate F/M strictly.

## Configuration
- DMEM_RANGE_CHECK_EN defined:
  - In IDLE, a granted address with addr > MEM_BYTES-8 (8-byte access overruns) skips BUSY and goes directly to RESP with err=1, rdata=0.
  - mem_req is never asserted for such an access.
  - The grant still updates the round-robin pointer.
- Not defined: no address check; every grant goes to BUSY. Only timeout produces err.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - port-id constants PORT_F=0, PORT_M=1;
  - the counter width derived from TIMEOUT.
- One sub-module: rr_arb2, a two-request round-robin picker with a last-grant register. It takes req[1:0] and an advance strobe and returns a one-hot grant.
- State machine, field latches, timeout counter and response muxing stay in dmem_arbiter.

## Test plan
- M write then read: m_we=1, m_addr=100, m_wdata=49, backend latency 0 → mem_req cycle 1, m_ack cycle 2, m_err=0. M read of 100 → m_rdata=49.
- Tie: f_req (addr 87) and m_req (read 200) both high from reset → M granted first, F second; f_ack follows m_ack by 3 cycles; next tie goes to M again only after F is served.
- Negative data: M writes -49 to 250, then reads it back → m_rdata = 64'hFFFF_FFFF_FFFF_FFCF, err=0.
- Timeout: backend never acks, TIMEOUT=15 → mem_req high exactly 15 cycles, then m_ack=1, m_err=1, m_rdata=0. Ack arriving on the 15th cycle → err=0.
- Range check (macro on): m_addr=1020, MEM_BYTES=1024 → mem_req never rises, m_ack one cycle after the grant with m_err=1. Macro off → backend access occurs.
- Reset mid-BUSY: assert rst while mem_req=1 → all outputs 0 asynchronously. After release, a fresh f_req is served normally.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the Y86-64 data-memory arbiter.
//   - state encoding for the arbiter FSM (IDLE, BUSY, RESP)
//   - requester port identifiers (PORT_F = Fetch, PORT_M = Memory stage)
//   - access size and the timeout-counter width helper
package dmem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_M = 1'b1;

  // Every access moves one 8-byte quadword.
  localparam int ACCESS_BYTES = 8;

  // The counter only has to hold 0 .. timeout-1.
  function automatic int cnt_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-request round-robin picker.
//   clk, rst  : clock, asynchronous active-high reset
//   req[1:0]  : request vector, bit 0 = Fetch, bit 1 = Memory stage
//   advance   : when high and a grant is produced, the grant is recorded
//               as the last-granted port
//   grant[1:0]: one-hot grant (combinational from req and the last-grant reg)
// After reset the last grant reads as Fetch, so the Memory stage wins the
// first tie.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == PORT_F) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= PORT_F;
    end else if (advance && (grant != 2'b00)) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the Fetch
// requester (read-only) and the Memory-stage requester (read/write).
// One backend transaction at a time; round-robin between the two ports.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   f_req, f_addr                    Fetch read request
//   f_ack, f_rdata, f_err            Fetch one-cycle response
//   m_req, m_we, m_addr, m_wdata     Memory-stage request
//   m_ack, m_rdata, m_err            Memory-stage one-cycle response
//   mem_req, mem_we, mem_addr,
//   mem_wdata                        backend request with latched fields
//   mem_ack, mem_rdata               backend completion and read data
//   busy                             high while a transaction is in flight
//
// Build option: define DMEM_RANGE_CHECK_EN to reject accesses whose 8 bytes
// would run past MEM_BYTES; such grants answer with err=1 straight away and
// never touch the backend.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = 64,
  parameter int DW        = 64,
  parameter int MEM_BYTES = 1024,
  parameter int TIMEOUT   = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  output logic          f_err,
  input  logic          m_req,
  input  logic          m_we,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_wdata,
  output logic          m_ack,
  output logic [DW-1:0] m_rdata,
  output logic          m_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int            CW        = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(MEM_BYTES - ACCESS_BYTES);
`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic          gnt_port;
  logic [1:0]    grant;
  logic          pick_m;
  logic [AW-1:0] pick_addr;
  logic          range_bad;
  logic          timed_out;

  // The picker only records a grant while IDLE, so requests raised during a
  // transaction cannot disturb the pointer.
  rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     ({m_req, f_req}),
    .advance (state == ST_IDLE),
    .grant   (grant)
  );

  assign pick_m    = grant[1];
  assign pick_addr = pick_m ? m_addr : f_addr;
  assign range_bad = RANGE_CHECK && (pick_addr > ADDR_LAST);
  // Counter value TIMEOUT-1 is the last BUSY cycle with mem_req high.
  assign timed_out = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      gnt_port  <= PORT_F;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      f_ack     <= 1'b0;
      f_rdata   <= '0;
      f_err     <= 1'b0;
      m_ack     <= 1'b0;
      m_rdata   <= '0;
      m_err     <= 1'b0;
    end else begin
      // Responses are single-cycle pulses; anything not set below is zero.
      f_ack   <= 1'b0;
      f_rdata <= '0;
      f_err   <= 1'b0;
      m_ack   <= 1'b0;
      m_rdata <= '0;
      m_err   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            gnt_port  <= pick_m;
            mem_we    <= pick_m & m_we;
            mem_addr  <= pick_addr;
            mem_wdata <= pick_m ? m_wdata : '0;
            cnt       <= '0;
            busy      <= 1'b1;
            if (range_bad) begin
              state <= ST_RESP;
              if (pick_m) begin
                m_ack <= 1'b1;
                m_err <= 1'b1;
              end else begin
                f_ack <= 1'b1;
                f_err <= 1'b1;
              end
            end else begin
              state   <= ST_BUSY;
              mem_req <= 1'b1;
            end
          end
        end

        ST_BUSY: begin
          // mem_ack takes priority over a coincident timeout.
          if (mem_ack || timed_out) begin
            state   <= ST_RESP;
            mem_req <= 1'b0;
            if (gnt_port == PORT_M) begin
              m_ack   <= 1'b1;
              m_err   <= ~mem_ack;
              m_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
            end else begin
              f_ack   <= 1'b1;
              f_err   <= ~mem_ack;
              f_rdata <= mem_ack ? mem_rdata : '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        f_req = 1'b0;
  logic [63:0] f_addr = '0;
  logic        f_ack;
  logic [63:0] f_rdata;
  logic        f_err;
  logic        m_req = 1'b0;
  logic        m_we = 1'b0;
  logic [63:0] m_addr = '0;
  logic [63:0] m_wdata = '0;
  logic        m_ack;
  logic [63:0] m_rdata;
  logic        m_err;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  localparam logic [63:0] K87   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] K200  = 64'h0000_0000_DEAD_BEEF;
  localparam logic [63:0] K300  = 64'h5555_AAAA_1234_0300;
  localparam logic [63:0] K1020 = 64'h0000_0000_0000_1020;

  dmem_arbiter #(.AW(64), .DW(64), .MEM_BYTES(1024), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata), .f_err(f_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Backend memory model: acks be_lat cycles into a request (100 = never).
  logic [63:0] be_mem [logic [63:0]];
  int be_lat = 0;
  int be_cnt = 0;

  always @(negedge clk) begin
    if (mem_req) begin
      if (be_cnt == be_lat) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          be_mem[mem_addr] = mem_wdata;
          mem_rdata = {$urandom, $urandom};
        end else begin
          mem_rdata = be_mem.exists(mem_addr) ? be_mem[mem_addr] : 64'h0;
        end
      end else begin
        mem_ack = 1'b0;
        mem_rdata = {$urandom, $urandom};
      end
      be_cnt++;
    end else begin
      mem_ack = 1'b0;
      be_cnt = 0;
      mem_rdata = {$urandom, $urandom};
    end
  end

  // Waits (bounded) for an ack on either port; ncyc counts negedges from the call.
  task automatic wait_resp(input int maxc, output bit got, output int ncyc, output int nreq,
                           output logic fa, output logic ma, output logic [63:0] fd,
                           output logic [63:0] md, output logic fe, output logic me);
    got = 0; ncyc = 0; nreq = 0;
    fa = 0; ma = 0; fd = '0; md = '0; fe = 0; me = 0;
    while (!got && ncyc < maxc) begin
      @(negedge clk);
      ncyc++;
      if (mem_req) nreq++;
      if (f_ack || m_ack) begin
        got = 1; fa = f_ack; ma = m_ack; fd = f_rdata; md = m_rdata; fe = f_err; me = m_err;
      end
    end
  endtask

  // One Memory-stage transaction, driven from an IDLE cycle.
  task automatic m_txn(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                       output bit got, output int ncyc, output int nreq, output logic ma,
                       output logic [63:0] md, output logic me, output bit f_any);
    logic fa, fe;
    logic [63:0] fd;
    @(negedge clk);
    m_req = 1; m_we = we; m_addr = addr; m_wdata = wd;
    wait_resp(60, got, ncyc, nreq, fa, ma, fd, md, fe, me);
    f_any = fa | (|fd) | fe;
    m_req = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    #2 rst = 1;
    #1;
    checks++;
    if ({f_ack, f_err, m_ack, m_err, mem_req, mem_we, busy} !== 7'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0", {f_ack, f_err, m_ack, m_err, mem_req, mem_we, busy});
    end
    checks++;
    if ({f_rdata, m_rdata, mem_addr, mem_wdata} !== 256'b0) begin
      failures++; $display("FAIL reset_data got=%0h exp=0", {f_rdata, m_rdata, mem_addr, mem_wdata});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_write_read();
    bit got, f_any; int nc, nr; logic ma, me; logic [63:0] md;
    be_lat = 0;
    m_txn(1'b1, 64'd100, 64'd49, got, nc, nr, ma, md, me, f_any);
    checks++;
    if (!(got && ma) || f_any) begin
      failures++; $display("FAIL wr_ack got=%0b m_ack=%0b f_any=%0b exp got=1 m_ack=1 f_any=0", got, ma, f_any);
    end
    checks++;
    if (nc != 2 || nr != 1) begin
      failures++; $display("FAIL wr_timing ack_cyc=%0d memreq_cyc=%0d exp 2 1", nc, nr);
    end
    checks++;
    if (me !== 1'b0 || md !== 64'h0) begin
      failures++; $display("FAIL wr_resp err=%0b rdata=%0h exp err=0 rdata=0", me, md);
    end
    m_txn(1'b0, 64'd100, 64'h0, got, nc, nr, ma, md, me, f_any);
    checks++;
    if (!(got && ma) || nc != 2 || md !== 64'd49 || me !== 1'b0) begin
      failures++; $display("FAIL rd_back got=%0b cyc=%0d rdata=%0h err=%0b exp 1 2 31 0", got, nc, md, me);
    end
    @(negedge clk);
    checks++;
    if (m_ack !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL ack_one_cycle m_ack=%0b busy=%0b exp 0 0", m_ack, busy);
    end
  endtask

  task automatic test_tie();
    bit got; int nc, nr; logic fa, ma, fe, me; logic [63:0] fd, md;
    be_lat = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    f_req = 1; f_addr = 64'd87;
    m_req = 1; m_we = 0; m_addr = 64'd200;
    wait_resp(60, got, nc, nr, fa, ma, fd, md, fe, me);
    checks++;
    if (!(got && ma && !fa) || nc != 2) begin
      failures++; $display("FAIL tie_first_m got=%0b m_ack=%0b f_ack=%0b cyc=%0d exp 1 1 0 2", got, ma, fa, nc);
    end
    checks++;
    if (md !== K200 || me !== 1'b0 || fd !== 64'h0 || fe !== 1'b0) begin
      failures++; $display("FAIL tie_m_data m_rdata=%0h m_err=%0b f_rdata=%0h f_err=%0b exp %0h 0 0 0", md, me, fd, fe, K200);
    end
    m_req = 0;
    wait_resp(60, got, nc, nr, fa, ma, fd, md, fe, me);
    checks++;
    if (!(got && fa && !ma) || nc != 3) begin
      failures++; $display("FAIL tie_second_f got=%0b f_ack=%0b m_ack=%0b gap=%0d exp 1 1 0 3", got, fa, ma, nc);
    end
    checks++;
    if (fd !== K87 || fe !== 1'b0 || md !== 64'h0 || me !== 1'b0) begin
      failures++; $display("FAIL tie_f_data f_rdata=%0h f_err=%0b m_rdata=%0h m_err=%0b exp %0h 0 0 0", fd, fe, md, me, K87);
    end
    f_req = 0;
    @(negedge clk);
    f_req = 1; m_req = 1;
    wait_resp(60, got, nc, nr, fa, ma, fd, md, fe, me);
    checks++;
    if (!(got && ma && !fa)) begin
      failures++; $display("FAIL tie_again_m got=%0b m_ack=%0b f_ack=%0b exp 1 1 0", got, ma, fa);
    end
    m_req = 0;
    wait_resp(60, got, nc, nr, fa, ma, fd, md, fe, me);
    checks++;
    if (!(got && fa && !ma) || fd !== K87) begin
      failures++; $display("FAIL tie_again_f got=%0b f_ack=%0b f_rdata=%0h exp 1 1 %0h", got, fa, fd, K87);
    end
    f_req = 0;
  endtask

  task automatic test_negative();
    bit got, f_any; int nc, nr; logic ma, me; logic [63:0] md;
    be_lat = 1;
    m_txn(1'b1, 64'd250, -64'sd49, got, nc, nr, ma, md, me, f_any);
    checks++;
    if (!(got && ma) || me !== 1'b0 || nc != 3) begin
      failures++; $display("FAIL neg_write got=%0b err=%0b cyc=%0d exp 1 0 3", got, me, nc);
    end
    m_txn(1'b0, 64'd250, 64'h0, got, nc, nr, ma, md, me, f_any);
    checks++;
    if (!(got && ma) || md !== 64'hFFFF_FFFF_FFFF_FFCF || me !== 1'b0) begin
      failures++; $display("FAIL neg_read got=%0b rdata=%0h err=%0b exp 1 ffffffffffffffcf 0", got, md, me);
    end
  endtask

  task automatic test_timeout();
    bit got, f_any; int nc, nr; logic ma, me; logic [63:0] md;
    be_lat = 100;
    m_txn(1'b0, 64'd300, 64'h0, got, nc, nr, ma, md, me, f_any);
    checks++;
    if (!(got && ma) || nr != TO || nc != TO + 1) begin
      failures++; $display("FAIL timeout_timing got=%0b memreq_cyc=%0d ack_cyc=%0d exp 1 %0d %0d", got, nr, nc, TO, TO + 1);
    end
    checks++;
    if (me !== 1'b1 || md !== 64'h0 || f_any) begin
      failures++; $display("FAIL timeout_resp err=%0b rdata=%0h f_any=%0b exp 1 0 0", me, md, f_any);
    end
    be_lat = TO - 1;
    m_txn(1'b0, 64'd300, 64'h0, got, nc, nr, ma, md, me, f_any);
    checks++;
    if (!(got && ma) || nr != TO || me !== 1'b0 || md !== K300) begin
      failures++; $display("FAIL ack_on_last got=%0b memreq_cyc=%0d err=%0b rdata=%0h exp 1 %0d 0 %0h", got, nr, me, md, TO, K300);
    end
    be_lat = TO;
    m_txn(1'b0, 64'd300, 64'h0, got, nc, nr, ma, md, me, f_any);
    checks++;
    if (!(got && ma) || me !== 1'b1 || md !== 64'h0) begin
      failures++; $display("FAIL ack_too_late got=%0b err=%0b rdata=%0h exp 1 1 0", got, me, md);
    end
  endtask

  task automatic test_range();
    bit got, f_any; int nc, nr; logic ma, me; logic [63:0] md;
    be_lat = 0;
    m_txn(1'b0, 64'd1020, 64'h0, got, nc, nr, ma, md, me, f_any);
`ifdef DMEM_RANGE_CHECK_EN
    checks++;
    if (!(got && ma) || nr != 0 || nc != 1 || me !== 1'b1 || md !== 64'h0) begin
      failures++; $display("FAIL range_on got=%0b memreq_cyc=%0d cyc=%0d err=%0b rdata=%0h exp 1 0 1 1 0", got, nr, nc, me, md);
    end
`else
    checks++;
    if (!(got && ma) || nr != 1 || nc != 2 || me !== 1'b0 || md !== K1020) begin
      failures++; $display("FAIL range_off got=%0b memreq_cyc=%0d cyc=%0d err=%0b rdata=%0h exp 1 1 2 0 %0h", got, nr, nc, me, md, K1020);
    end
`endif
  endtask

  task automatic test_reset_mid_busy();
    bit got; int nc, nr; logic fa, ma, fe, me; logic [63:0] fd, md;
    be_lat = 100;
    @(negedge clk);
    m_req = 1; m_we = 1; m_addr = 64'd400; m_wdata = 64'h77;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL busy_before_rst mem_req=%0b busy=%0b exp 1 1", mem_req, busy);
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({f_ack, f_err, m_ack, m_err, mem_req, mem_we, busy} !== 7'b0) begin
      failures++; $display("FAIL midrst_ctrl got=%b exp=0", {f_ack, f_err, m_ack, m_err, mem_req, mem_we, busy});
    end
    checks++;
    if ({f_rdata, m_rdata, mem_addr, mem_wdata} !== 256'b0) begin
      failures++; $display("FAIL midrst_data got=%0h exp=0", {f_rdata, m_rdata, mem_addr, mem_wdata});
    end
    @(negedge clk);
    rst = 0; m_req = 0; m_we = 0;
    be_lat = 0;
    @(negedge clk);
    f_req = 1; f_addr = 64'd87;
    wait_resp(60, got, nc, nr, fa, ma, fd, md, fe, me);
    f_req = 0;
    checks++;
    if (!(got && fa && !ma) || nc != 2 || fd !== K87 || fe !== 1'b0) begin
      failures++; $display("FAIL post_rst_fetch got=%0b f_ack=%0b cyc=%0d rdata=%0h err=%0b exp 1 1 2 %0h 0", got, fa, nc, fd, fe, K87);
    end
  endtask

  // Transaction-level reference: arbitration order from the round-robin rule,
  // latency from the backend delay capped by the timeout, data from a shadow
  // memory updated by every write that completed without error.
  task automatic test_random();
    logic [63:0] ref_mem [logic [63:0]];
    bit got, pf, pm, last_m, first_m, port_m, exp_err;
    int nc, nr, lat, eff, nports, r;
    logic fa, ma, fe, me, we;
    logic [63:0] fd, md, fa_addr, ma_addr, wd, exp_d, got_d, oth_d;
    logic got_e, oth_a, oth_e;
    pulse_reset();
    last_m = 0;
    for (int it = 0; it < 30; it++) begin
      pf = $urandom_range(0, 1);
      pm = $urandom_range(0, 1);
      if (!pf && !pm) pm = 1;
      r = $urandom_range(0, 9);
      lat = (r < 7) ? $urandom_range(0, 3) : (r == 7) ? TO - 1 : (r == 8) ? TO : 100;
      fa_addr = 64'd512 + 64'(8 * $urandom_range(0, 63));
      ma_addr = 64'd512 + 64'(8 * $urandom_range(0, 63));
      we = $urandom_range(0, 1);
      wd = {$urandom, $urandom};
      be_lat = lat;
      @(negedge clk);
      f_req = pf; f_addr = fa_addr;
      m_req = pm; m_we = we; m_addr = ma_addr; m_wdata = wd;
      first_m = pm && (!pf || !last_m);
      nports = (pf && pm) ? 2 : 1;
      eff = (lat < TO) ? lat : TO - 1;
      exp_err = (lat >= TO);
      for (int k = 0; k < nports; k++) begin
        port_m = (k == 0) ? first_m : !first_m;
        wait_resp(60, got, nc, nr, fa, ma, fd, md, fe, me);
        if (exp_err || (port_m && we)) exp_d = 64'h0;
        else begin
          exp_d = port_m ? ma_addr : fa_addr;
          exp_d = ref_mem.exists(exp_d) ? ref_mem[exp_d] : 64'h0;
        end
        if (port_m && we && !exp_err) ref_mem[ma_addr] = wd;
        got_d = port_m ? md : fd;  got_e = port_m ? me : fe;
        oth_d = port_m ? fd : md;  oth_e = port_m ? fe : me;  oth_a = port_m ? fa : ma;
        checks++;
        if (!got || ma !== port_m || fa !== !port_m) begin
          failures++; $display("FAIL rnd_port it=%0d k=%0d got=%0b m_ack=%0b f_ack=%0b exp m_ack=%0b", it, k, got, ma, fa, port_m);
        end
        checks++;
        if (nc != ((k == 0) ? 2 : 3) + eff || nr != eff + 1) begin
          failures++; $display("FAIL rnd_timing it=%0d k=%0d ack_cyc=%0d memreq_cyc=%0d exp %0d %0d", it, k, nc, nr, ((k == 0) ? 2 : 3) + eff, eff + 1);
        end
        checks++;
        if (got_d !== exp_d || got_e !== exp_err) begin
          failures++; $display("FAIL rnd_resp it=%0d k=%0d rdata=%0h err=%0b exp %0h %0b", it, k, got_d, got_e, exp_d, exp_err);
        end
        checks++;
        if (oth_a !== 1'b0 || oth_d !== 64'h0 || oth_e !== 1'b0) begin
          failures++; $display("FAIL rnd_other it=%0d k=%0d ack=%0b rdata=%0h err=%0b exp 0 0 0", it, k, oth_a, oth_d, oth_e);
        end
        if (ma) m_req = 0;
        else if (fa) f_req = 0;
        else begin
          f_req = 0; m_req = 0;
        end
        last_m = port_m;
      end
      f_req = 0; m_req = 0;
    end
  endtask

  initial begin
    be_mem[64'd87]   = K87;
    be_mem[64'd200]  = K200;
    be_mem[64'd300]  = K300;
    be_mem[64'd1020] = K1020;
    test_reset();
    test_write_read();
    test_tie();
    test_negative();
    test_timeout();
    test_range();
    test_reset_mid_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
